instr_fetch_unit: RTL and testbench

Front-end fetch block of the CPU pipeline. Owns the program counter (F stage), drives the instruction bus, and produces the IF2-stage PC/instruction/valid consumed by the decode register. Acts on the stall, clear and zero controls from the hazard unit and on branch redirects resolved in M. Includes a one-entry hold register so an instruction returned while decode is stalled is not lost.

---
 rtl/instr_fetch_unit.sv | 158 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Front end of the CPU pipeline. It owns the F-stage program counter, drives
// the instruction bus, and produces the IF2-stage PC, instruction and valid
// flag that the decode register consumes. It responds to the hazard unit's
// stall, clear and zero controls, and to branch redirects resolved in M.
//
// A one-entry hold register keeps an instruction that comes back while decode
// is stalled. Instruction data is only on the bus for the one cycle after the
// read is accepted, so without this register that word would be lost.
//
// Parameters
//   RESET_PC          PC value loaded on reset.
//
// Ports
//   i_Clk             single clock
//   i_Rst             synchronous, active-high reset
//   i_PcEn            PC advance/redirect enable (hazard unit)
//   i_IBusRdEn        instruction-bus read enable (hazard unit)
//   i_IBusOZero       force the IF2 instruction to zero and mark it invalid
//   i_RegEn_IF2       F->IF2 register enable
//   i_RegClr_IF2      F->IF2 register clear (wins over the enable)
//   i_RegEn_D         decode register enable (IF2 instruction consumed)
//   i_TakeBranch_M    redirect request from M
//   i_BranchTarget_M  redirect target (low two bits ignored)
//   o_IBusAddr        read address (F-stage PC)
//   o_IBusRdReq       read request
//   i_IBusWaitReq_F   slave stall; the request is not accepted while high
//   i_IBusRdData      read data, valid one cycle after acceptance
//   o_IBusWaitReq_F   combinational copy of i_IBusWaitReq_F
//   o_Pc_F            current F-stage PC
//   o_Pc_IF2          PC of the IF2 instruction
//   o_Instr_IF2       IF2 instruction
//   o_Valid_IF2       IF2 holds a real instruction
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_PcEn,
    input  logic        i_IBusRdEn,
    input  logic        i_IBusOZero,
    input  logic        i_RegEn_IF2,
    input  logic        i_RegClr_IF2,
    input  logic        i_RegEn_D,
    input  logic        i_TakeBranch_M,
    input  logic [31:0] i_BranchTarget_M,
    output logic [31:0] o_IBusAddr,
    output logic        o_IBusRdReq,
    input  logic        i_IBusWaitReq_F,
    input  logic [31:0] i_IBusRdData,
    output logic        o_IBusWaitReq_F,
    output logic [31:0] o_Pc_F,
    output logic [31:0] o_Pc_IF2,
    output logic [31:0] o_Instr_IF2,
    output logic        o_Valid_IF2
);

    localparam int DATA_W = 32;

    // Force a byte address onto a word boundary. The mask uses every bit of
    // the input, so the ignored low bits are handled deliberately.
    function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] addr);
        return addr & ~DATA_W'(3);
    endfunction

    // Sequential next PC. The add wraps modulo 2^32, so 32'hFFFF_FFFC
    // goes to 0.
    function automatic logic [DATA_W-1:0] next_seq_pc(input logic [DATA_W-1:0] pc);
        return pc + DATA_W'(4);
    endfunction

    logic [DATA_W-1:0] pc_p0;
    logic              rd_req_p0;
    logic              accept_p0;
    logic              redirect_p0;
    logic              advance_p0;
    logic              fetch_vld_p0;

    logic [DATA_W-1:0] pc_p1;
    logic              vld_p1;
    logic [DATA_W-1:0] hold_p1;
    logic              hold_vld_p1;
    logic              hold_clr_p1;
    logic              hold_cap_p1;

    // ---- F stage (p0): bus request, acceptance, PC update ----
    always_comb begin
        rd_req_p0    = i_IBusRdEn & ~i_Rst;
        accept_p0    = rd_req_p0 & ~i_IBusWaitReq_F;
        redirect_p0  = i_PcEn & i_TakeBranch_M;
        advance_p0   = i_PcEn & accept_p0;
        // A fetch accepted in the same cycle as a redirect is on the wrong
        // path, so it goes into IF2 as a bubble.
        fetch_vld_p0 = accept_p0 & i_PcEn & ~i_TakeBranch_M;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            pc_p0 <= RESET_PC;
        end else if (redirect_p0) begin
            pc_p0 <= word_align(i_BranchTarget_M);
        end else if (advance_p0) begin
            pc_p0 <= next_seq_pc(pc_p0);
        end
    end

    // ---- IF2 stage (p1): PC/valid register and decode-stall hold ----
    always_ff @(posedge i_Clk) begin
        if (i_Rst || i_RegClr_IF2) begin
            vld_p1 <= 1'b0;
            pc_p1  <= '0;
        end else if (i_RegEn_IF2) begin
            vld_p1 <= fetch_vld_p0;
            pc_p1  <= pc_p0;
        end
    end

    // Capture on the first stalled cycle only. After that the bus data is
    // stale and must not overwrite the held word. Clearing wins over
    // capturing.
    always_comb begin
        hold_clr_p1 = i_Rst | i_RegEn_D | i_RegClr_IF2;
        hold_cap_p1 = vld_p1 & ~hold_vld_p1 & ~i_RegEn_D;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            hold_vld_p1 <= 1'b0;
            hold_p1     <= '0;
        end else if (hold_clr_p1) begin
            hold_vld_p1 <= 1'b0;
        end else if (hold_cap_p1) begin
            hold_vld_p1 <= 1'b1;
            hold_p1     <= i_IBusRdData;
        end
    end

    // ---- Outputs ----
    always_comb begin
        o_IBusAddr      = pc_p0;
        o_IBusRdReq     = rd_req_p0;
        o_IBusWaitReq_F = i_IBusWaitReq_F;
        o_Pc_F          = pc_p0;
        o_Pc_IF2        = pc_p1;
        o_Valid_IF2     = vld_p1 & ~i_IBusOZero;
        if (i_IBusOZero) begin
            o_Instr_IF2 = '0;
        end else if (hold_vld_p1) begin
            o_Instr_IF2 = hold_p1;
        end else begin
            o_Instr_IF2 = i_IBusRdData;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit with RESET_PC = 32'h100. A small
// instruction-bus slave returns {16'hC0DE, addr[15:0]} one cycle after each
// accepted read. It can also be switched to drive a fixed word every cycle,
// which stands in for changing or garbage bus data. Inputs change 1 ns after
// the rising edge, and outputs are sampled 1 ns after that.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_en;
    logic        rd_en;
    logic        ozero;
    logic        reg_en_if2;
    logic        reg_clr_if2;
    logic        reg_en_d;
    logic        take;
    logic [31:0] target;
    logic [31:0] addr;
    logic        rd_req;
    logic        wait_req;
    logic [31:0] rdata;
    logic        wait_out;
    logic [31:0] pc_f;
    logic [31:0] pc_if2;
    logic [31:0] instr_if2;
    logic        valid_if2;

    logic        bus_mode;
    logic [31:0] bus_const;

    int checks = 0;
    int failures = 0;

    instr_fetch_unit #(.RESET_PC(32'h100)) dut (
        .i_Clk           (clk),
        .i_Rst           (rst),
        .i_PcEn          (pc_en),
        .i_IBusRdEn      (rd_en),
        .i_IBusOZero     (ozero),
        .i_RegEn_IF2     (reg_en_if2),
        .i_RegClr_IF2    (reg_clr_if2),
        .i_RegEn_D       (reg_en_d),
        .i_TakeBranch_M  (take),
        .i_BranchTarget_M(target),
        .o_IBusAddr      (addr),
        .o_IBusRdReq     (rd_req),
        .i_IBusWaitReq_F (wait_req),
        .i_IBusRdData    (rdata),
        .o_IBusWaitReq_F (wait_out),
        .o_Pc_F          (pc_f),
        .o_Pc_IF2        (pc_if2),
        .o_Instr_IF2     (instr_if2),
        .o_Valid_IF2     (valid_if2)
    );

    always #5 clk = ~clk;

    // Instruction-bus slave.
    always @(posedge clk) begin
        if (bus_mode) rdata <= bus_const;
        else if (rd_req && !wait_req) rdata <= {16'hC0DE, addr[15:0]};
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_run;
        pc_en = 1'b1; rd_en = 1'b1; reg_en_if2 = 1'b1; reg_en_d = 1'b1;
    endtask

    task automatic set_stall;
        pc_en = 1'b0; reg_en_if2 = 1'b0; reg_en_d = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; set_run(); ozero = 1'b0; reg_clr_if2 = 1'b0; take = 1'b0;
        target = 32'h0; wait_req = 1'b0; bus_mode = 1'b1; bus_const = 32'h1234_5678;
        tick(); tick(); tick();
        checks++; if (rd_req !== 1'b0) begin failures++; $display("FAIL rst_rdreq: got %b exp 0", rd_req); end
        checks++; if (valid_if2 !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b exp 0", valid_if2); end
        checks++; if (pc_f !== 32'h100) begin failures++; $display("FAIL rst_pc_f: got %h exp 00000100", pc_f); end
        checks++; if (addr !== 32'h100) begin failures++; $display("FAIL rst_addr: got %h exp 00000100", addr); end
        checks++; if (pc_if2 !== 32'h0) begin failures++; $display("FAIL rst_pc_if2: got %h exp 00000000", pc_if2); end
        checks++; if (instr_if2 !== 32'h1234_5678) begin failures++; $display("FAIL rst_instr: got %h exp 12345678", instr_if2); end
        ozero = 1'b1; #1;
        checks++; if (instr_if2 !== 32'h0) begin failures++; $display("FAIL rst_ozero_instr: got %h exp 00000000", instr_if2); end
        ozero = 1'b0; wait_req = 1'b1; #1;
        checks++; if (wait_out !== 1'b1) begin failures++; $display("FAIL wait_pass_1: got %b exp 1", wait_out); end
        wait_req = 1'b0; #1;
        checks++; if (wait_out !== 1'b0) begin failures++; $display("FAIL wait_pass_0: got %b exp 0", wait_out); end
    endtask

    task automatic test_free_run;
        logic [31:0] exp_addr  [3] = '{32'h100, 32'h104, 32'h108};
        logic [31:0] exp_pc    [3] = '{32'h0, 32'h100, 32'h104};
        logic [31:0] exp_instr [3] = '{32'h0, 32'hC0DE_0100, 32'hC0DE_0104};
        logic        exp_vld   [3] = '{1'b0, 1'b1, 1'b1};
        bus_mode = 1'b0; rst = 1'b0; #1;
        checks++; if (rd_req !== 1'b1) begin failures++; $display("FAIL fr_first_req: got %b exp 1", rd_req); end
        for (int c = 0; c < 3; c++) begin
            if (c > 0) tick();
            checks++; if (addr !== exp_addr[c]) begin failures++; $display("FAIL fr_addr[%0d]: got %h exp %h", c, addr, exp_addr[c]); end
            checks++; if (valid_if2 !== exp_vld[c]) begin failures++; $display("FAIL fr_valid[%0d]: got %b exp %b", c, valid_if2, exp_vld[c]); end
            if (c > 0) begin
                checks++; if (pc_if2 !== exp_pc[c]) begin failures++; $display("FAIL fr_pc_if2[%0d]: got %h exp %h", c, pc_if2, exp_pc[c]); end
                checks++; if (instr_if2 !== exp_instr[c]) begin failures++; $display("FAIL fr_instr[%0d]: got %h exp %h", c, instr_if2, exp_instr[c]); end
            end
        end
    endtask

    task automatic test_waitreq;
        wait_req = 1'b1; #1;
        checks++; if (addr !== 32'h108) begin failures++; $display("FAIL wr_addr_first: got %h exp 00000108", addr); end
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 2) wait_req = 1'b0;
            #1;
            checks++; if (addr !== 32'h108) begin failures++; $display("FAIL wr_addr_hold[%0d]: got %h exp 00000108", k, addr); end
            checks++; if (valid_if2 !== 1'b0) begin failures++; $display("FAIL wr_bubble[%0d]: got %b exp 0", k, valid_if2); end
        end
        tick();
        checks++; if (addr !== 32'h10C) begin failures++; $display("FAIL wr_addr_next: got %h exp 0000010c", addr); end
        checks++; if (pc_if2 !== 32'h108) begin failures++; $display("FAIL wr_pc_if2: got %h exp 00000108", pc_if2); end
        checks++; if (instr_if2 !== 32'hC0DE_0108) begin failures++; $display("FAIL wr_instr: got %h exp c0de0108", instr_if2); end
        checks++; if (valid_if2 !== 1'b1) begin failures++; $display("FAIL wr_valid: got %b exp 1", valid_if2); end
    endtask

    task automatic test_branch;
        tick();
        take = 1'b1; target = 32'h2003; #1;
        checks++; if (addr !== 32'h110) begin failures++; $display("FAIL br_addr_110: got %h exp 00000110", addr); end
        checks++; if (pc_if2 !== 32'h10C) begin failures++; $display("FAIL br_pc_if2_10c: got %h exp 0000010c", pc_if2); end
        tick();
        take = 1'b0; #1;
        checks++; if (addr !== 32'h2000) begin failures++; $display("FAIL br_target: got %h exp 00002000", addr); end
        checks++; if (valid_if2 !== 1'b0) begin failures++; $display("FAIL br_discard: got %b exp 0", valid_if2); end
        tick();
        checks++; if (addr !== 32'h2004) begin failures++; $display("FAIL br_addr_2004: got %h exp 00002004", addr); end
        checks++; if (pc_if2 !== 32'h2000) begin failures++; $display("FAIL br_pc_if2: got %h exp 00002000", pc_if2); end
        checks++; if (instr_if2 !== 32'hC0DE_2000) begin failures++; $display("FAIL br_instr: got %h exp c0de2000", instr_if2); end
        checks++; if (valid_if2 !== 1'b1) begin failures++; $display("FAIL br_valid: got %b exp 1", valid_if2); end
    endtask

    task automatic test_decode_stall;
        bus_mode = 1'b1; bus_const = 32'hDEAD_BEEF;
        tick();
        checks++; if (instr_if2 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ds_instr_first: got %h exp deadbeef", instr_if2); end
        bus_const = 32'h0; set_stall(); #1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (instr_if2 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ds_instr_hold[%0d]: got %h exp deadbeef", k, instr_if2); end
            checks++; if (valid_if2 !== 1'b1) begin failures++; $display("FAIL ds_valid[%0d]: got %b exp 1", k, valid_if2); end
            checks++; if (pc_if2 !== 32'h2004) begin failures++; $display("FAIL ds_pc_if2[%0d]: got %h exp 00002004", k, pc_if2); end
            checks++; if (addr !== 32'h2008) begin failures++; $display("FAIL ds_addr[%0d]: got %h exp 00002008", k, addr); end
        end
        tick();
        set_run(); bus_mode = 1'b0; #1;
        checks++; if (instr_if2 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ds_instr_release: got %h exp deadbeef", instr_if2); end
        tick();
        checks++; if (pc_if2 !== 32'h2008) begin failures++; $display("FAIL ds_pc_after: got %h exp 00002008", pc_if2); end
        checks++; if (instr_if2 !== 32'hC0DE_2008) begin failures++; $display("FAIL ds_instr_after: got %h exp c0de2008", instr_if2); end
        checks++; if (addr !== 32'h200C) begin failures++; $display("FAIL ds_addr_after: got %h exp 0000200c", addr); end
    endtask

    task automatic test_clear_ozero;
        set_stall(); bus_mode = 1'b1; bus_const = 32'h0;
        tick();
        checks++; if (instr_if2 !== 32'hC0DE_2008) begin failures++; $display("FAIL cl_hold_instr: got %h exp c0de2008", instr_if2); end
        reg_clr_if2 = 1'b1;
        tick();
        reg_clr_if2 = 1'b0; #1;
        checks++; if (valid_if2 !== 1'b0) begin failures++; $display("FAIL cl_valid: got %b exp 0", valid_if2); end
        checks++; if (pc_if2 !== 32'h0) begin failures++; $display("FAIL cl_pc_if2: got %h exp 00000000", pc_if2); end
        checks++; if (instr_if2 !== 32'h0) begin failures++; $display("FAIL cl_hold_released: got %h exp 00000000", instr_if2); end
        set_run(); bus_mode = 1'b0; #1;
        checks++; if (addr !== 32'h200C) begin failures++; $display("FAIL cl_addr: got %h exp 0000200c", addr); end
        tick();
        checks++; if (pc_if2 !== 32'h200C) begin failures++; $display("FAIL cl_pc_refetch: got %h exp 0000200c", pc_if2); end
        ozero = 1'b1; #1;
        checks++; if (instr_if2 !== 32'h0) begin failures++; $display("FAIL oz_instr: got %h exp 00000000", instr_if2); end
        checks++; if (valid_if2 !== 1'b0) begin failures++; $display("FAIL oz_valid: got %b exp 0", valid_if2); end
        ozero = 1'b0; #1;
        checks++; if (instr_if2 !== 32'hC0DE_200C) begin failures++; $display("FAIL oz_off_instr: got %h exp c0de200c", instr_if2); end
        checks++; if (valid_if2 !== 1'b1) begin failures++; $display("FAIL oz_off_valid: got %b exp 1", valid_if2); end
    endtask

    task automatic test_wrap;
        take = 1'b1; target = 32'hFFFF_FFFF;
        tick();
        take = 1'b0; #1;
        checks++; if (addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wp_addr_top: got %h exp fffffffc", addr); end
        tick();
        checks++; if (addr !== 32'h0) begin failures++; $display("FAIL wp_addr_zero: got %h exp 00000000", addr); end
        checks++; if (pc_if2 !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wp_pc_if2: got %h exp fffffffc", pc_if2); end
        checks++; if (instr_if2 !== 32'hC0DE_FFFC) begin failures++; $display("FAIL wp_instr: got %h exp c0defffc", instr_if2); end
        tick();
        checks++; if (addr !== 32'h4) begin failures++; $display("FAIL wp_addr_four: got %h exp 00000004", addr); end
        checks++; if (pc_if2 !== 32'h0) begin failures++; $display("FAIL wp_pc_if2_zero: got %h exp 00000000", pc_if2); end
    endtask

    task automatic test_reset_midstall;
        set_stall(); bus_mode = 1'b1; bus_const = 32'h5555_AAAA;
        tick();
        checks++; if (instr_if2 !== 32'hC0DE_0000) begin failures++; $display("FAIL rm_hold: got %h exp c0de0000", instr_if2); end
        wait_req = 1'b1; rst = 1'b1;
        tick();
        checks++; if (pc_f !== 32'h100) begin failures++; $display("FAIL rm_pc_f: got %h exp 00000100", pc_f); end
        checks++; if (rd_req !== 1'b0) begin failures++; $display("FAIL rm_rdreq: got %b exp 0", rd_req); end
        checks++; if (valid_if2 !== 1'b0) begin failures++; $display("FAIL rm_valid: got %b exp 0", valid_if2); end
        checks++; if (pc_if2 !== 32'h0) begin failures++; $display("FAIL rm_pc_if2: got %h exp 00000000", pc_if2); end
        checks++; if (instr_if2 !== 32'h5555_AAAA) begin failures++; $display("FAIL rm_no_hold: got %h exp 5555aaaa", instr_if2); end
        rst = 1'b0; wait_req = 1'b0; set_run(); bus_mode = 1'b0; #1;
        checks++; if (addr !== 32'h100 || rd_req !== 1'b1) begin failures++; $display("FAIL rm_first_req: got addr %h req %b exp 00000100 1", addr, rd_req); end
        tick();
        checks++; if (pc_if2 !== 32'h100) begin failures++; $display("FAIL rm_pc_if2_after: got %h exp 00000100", pc_if2); end
        checks++; if (instr_if2 !== 32'hC0DE_0100) begin failures++; $display("FAIL rm_instr_after: got %h exp c0de0100", instr_if2); end
        checks++; if (valid_if2 !== 1'b1) begin failures++; $display("FAIL rm_valid_after: got %b exp 1", valid_if2); end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_free_run();
        test_waitreq();
        test_branch();
        test_decode_stall();
        test_clear_ozero();
        test_wrap();
        test_reset_midstall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
